// File: rtl/ts_sync_align.sv
// MPEG-TS sync acquisition: hunts for the sync byte, verifies packet spacing,
// then forwards whole aligned packets with a byte-0 strobe and flywheel timing.
module ts_sync_align #(
    parameter int          LOCK_COUNT   = 3,
    parameter int          UNLOCK_COUNT = 3,
    parameter logic [7:0]  SYNC_BYTE    = 8'h47
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Valid,
    input  logic [7:0]  i_Data,
    input  logic [7:0]  i_PacketLength,
    output logic        o_Valid,
    output logic        o_Sync,
    output logic [7:0]  o_Data,
    output logic [7:0]  o_PacketLength,
    output logic        o_Locked,
    output logic [15:0] o_SyncErrCnt
);
    localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_COUNT);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

    state_t      state, state_nxt;
    logic [7:0]  pos, pos_nxt, len, len_nxt;
    logic [7:0]  hits, hits_nxt, miss, miss_nxt;
    logic [15:0] err_nxt;
    logic        fwd, fwd_sync, locked_nxt;
    logic        at_sync, is_sync, len_ok;
    logic [7:0]  pos_inc;

    assign at_sync        = (pos == 8'd0);
    assign is_sync        = (i_Data == SYNC_BYTE);
    assign len_ok         = (i_PacketLength >= 8'd16);
    assign pos_inc        = (pos == len - 8'd1) ? 8'd0 : pos + 8'd1;
    assign o_PacketLength = len;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state        <= HUNT;
            pos          <= 8'd0;
            len          <= 8'd0;
            hits         <= 8'd0;
            miss         <= 8'd0;
            o_Valid      <= 1'b0;
            o_Sync       <= 1'b0;
            o_Data       <= 8'd0;
            o_Locked     <= 1'b0;
            o_SyncErrCnt <= 16'd0;
        end else begin
            state        <= state_nxt;
            pos          <= pos_nxt;
            len          <= len_nxt;
            hits         <= hits_nxt;
            miss         <= miss_nxt;
            o_Valid      <= fwd;
            o_Sync       <= fwd_sync;
            o_Locked     <= locked_nxt;
            o_SyncErrCnt <= err_nxt;
            if (fwd) begin
                o_Data <= i_Data;
            end
        end
    end

    // Invalid cycles leave every counter untouched, so gaps are transparent.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        len_nxt   = len;
        hits_nxt  = hits;
        miss_nxt  = miss;
        err_nxt   = o_SyncErrCnt;
        if (i_Valid) begin
            case (state)
                HUNT: begin
                    if (is_sync && len_ok) begin
                        state_nxt = VERIFY;
                        len_nxt   = i_PacketLength;
                        pos_nxt   = 8'd1;
                        hits_nxt  = 8'd1;
                    end
                end
                VERIFY: begin
                    pos_nxt = pos_inc;
                    if (at_sync) begin
                        if (is_sync) begin
                            hits_nxt = hits + 8'd1;
                            if (hits + 8'd1 == LOCK_N) begin
                                state_nxt = LOCK;
                                miss_nxt  = 8'd0;
                            end
                        end else begin
                            state_nxt = HUNT;
                        end
                    end
                end
                LOCK: begin
                    pos_nxt = pos_inc;
                    if (at_sync) begin
                        if (is_sync) begin
                            miss_nxt = 8'd0;
                        end else begin
                            miss_nxt = miss + 8'd1;
                            if (o_SyncErrCnt != 16'hFFFF) begin
                                err_nxt = o_SyncErrCnt + 16'd1;
                            end
                            if (miss + 8'd1 == UNLOCK_N) begin
                                state_nxt = HUNT;
                            end
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // A byte is forwarded only when it starts or continues a locked packet.
    always_comb begin
        fwd        = 1'b0;
        fwd_sync   = 1'b0;
        locked_nxt = (state_nxt == LOCK);
        if (i_Valid && state_nxt == LOCK && state != HUNT) begin
            fwd      = 1'b1;
            fwd_sync = at_sync;
        end
    end
endmodule
